refclk_ibuf_gate_div: RTL and testbench

//  Receive-side counterpart of the differential refclk output buffer: models the refclk

---
 rtl/refclk_ibuf_gate_div.sv | 118 +++++++++++
 tb/tb_refclk_ibuf_gate_div.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/refclk_ibuf_gate_div.sv
// Refclk input buffer model: CEB-gated settle, run and drain FSM
// with an ODIV2-style divided output, all in the refclk domain.
module refclk_ibuf_gate_div #(
   parameter logic [1:0] HROW_CK_SEL   = 2'b00,
   parameter int         DIV           = 2,
   parameter int         SETTLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ceb,
   output logic       ready,
   output logic       o_en,
   output logic       odiv2,
   output logic [7:0] dis_cnt
);

   localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [DW-1:0] DMAX  = DW'(DIV - 1);
   localparam logic [DW-1:0] DHALF = DW'(DIV / 2);
   localparam logic [SW-1:0] SMAX  = SW'(SETTLE_CYCLES - 1);

   localparam logic [1:0] ST_OFF    = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   generate
      if ((DIV < 2) || (DIV % 2 != 0) || (SETTLE_CYCLES < 1)) begin : g_bad_attr
         initial begin
            $display("Attribute Syntax Error %m");
            $finish;
         end
      end
   endgenerate

   logic [1:0]    r_state;
   logic          r_ceb_q;
   logic [SW-1:0] r_settle_cnt;
   logic [DW-1:0] r_div_cnt;
   logic [7:0]    r_dis_cnt;

   logic          w_active;
   logic          w_div_wrap;
   logic [DW-1:0] w_div_nxt;

   assign w_div_wrap = (r_div_cnt == DMAX);
   assign w_div_nxt  = w_div_wrap ? '0 : r_div_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_OFF;
         r_ceb_q      <= 1'b1;
         r_settle_cnt <= '0;
         r_div_cnt    <= '0;
         r_dis_cnt    <= '0;
      end else begin
         r_ceb_q <= ceb;
         unique case (r_state)
            ST_OFF: begin
               if (!r_ceb_q) begin
                  r_state      <= ST_SETTLE;
                  r_settle_cnt <= '0;
               end
            end
            ST_SETTLE: begin
               r_settle_cnt <= r_settle_cnt + 1'b1;
               if (r_ceb_q) begin
                  r_state <= ST_OFF;
               end else if (r_settle_cnt == SMAX) begin
                  r_state   <= ST_RUN;
                  r_div_cnt <= '0;
               end
            end
            ST_RUN: begin
               r_div_cnt <= w_div_nxt;
               if (r_ceb_q) begin
                  r_state <= ST_DRAIN;
                  if (r_dis_cnt != 8'hFF)
                     r_dis_cnt <= r_dis_cnt + 8'd1;
               end
            end
            ST_DRAIN: begin
               // Re-enable keeps the divider phase; otherwise exit on wrap.
               if (!r_ceb_q) begin
                  r_state   <= ST_RUN;
                  r_div_cnt <= w_div_nxt;
               end else if (w_div_wrap) begin
                  r_state   <= ST_OFF;
                  r_div_cnt <= '0;
               end else begin
                  r_div_cnt <= w_div_nxt;
               end
            end
            default: r_state <= ST_OFF;
         endcase
      end
   end

   assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);

   always_comb begin
      odiv2 = 1'b0;
      if (w_active) begin
         unique case (HROW_CK_SEL)
            2'b00:   odiv2 = (r_div_cnt < DHALF);
            2'b01:   odiv2 = w_div_wrap;
            default: odiv2 = 1'b0;
         endcase
      end
   end

   assign ready   = w_active;
   assign o_en    = w_active;
   assign dis_cnt = r_dis_cnt;

endmodule

// File: tb/tb_refclk_ibuf_gate_div.sv
// Directed bench for refclk_ibuf_gate_div: two instances, DIV=4,
// SETTLE_CYCLES=16, odiv2 modes 00 and 01 sharing clk/rst/ceb.
module tb_refclk_ibuf_gate_div;

   logic       clk;
   logic       rst;
   logic       ceb;
   logic       a_ready, a_en, a_div;
   logic [7:0] a_dis;
   logic       b_ready, b_en, b_div;
   logic [7:0] b_dis;

   int n_chk;
   int n_err;

   refclk_ibuf_gate_div #(
      .HROW_CK_SEL(2'b00), .DIV(4), .SETTLE_CYCLES(16)
   ) u_dut_a (
      .clk(clk), .rst(rst), .ceb(ceb),
      .ready(a_ready), .o_en(a_en),
      .odiv2(a_div), .dis_cnt(a_dis)
   );

   refclk_ibuf_gate_div #(
      .HROW_CK_SEL(2'b01), .DIV(4), .SETTLE_CYCLES(16)
   ) u_dut_b (
      .clk(clk), .rst(rst), .ceb(ceb),
      .ready(b_ready), .o_en(b_en),
      .odiv2(b_div), .dis_cnt(b_dis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int rdy,
                          input int da, input int db, input int dis);
      check({tag, ".ready"}, int'(a_ready), rdy);
      check({tag, ".o_en"}, int'(a_en), rdy);
      check({tag, ".odiv2_00"}, int'(a_div), da);
      check({tag, ".odiv2_01"}, int'(b_div), db);
      check({tag, ".dis"}, int'(a_dis), dis);
      check({tag, ".b_dis"}, int'(b_dis), dis);
      check({tag, ".b_ready"}, int'(b_ready), rdy);
      check({tag, ".b_en"}, int'(b_en), rdy);
   endtask

   task automatic settle(input string tag);
      // ceb already low before this call; edge k is the first tick
      tick();
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 16) check({tag, ".early"}, int'(a_ready), 0);
      end
      tick();
      check({tag, ".ready"}, int'(a_ready), 1);
      check({tag, ".o_en"}, int'(b_en), 1);
   endtask

   int p00 [4] = '{1, 1, 0, 0};
   int p01 [4] = '{0, 0, 0, 1};

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      ceb = 1'b1;

      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out("reset", 0, 0, 0, 0);
      end
      rst = 1'b0;
      tick();
      chk_out("off", 0, 0, 0, 0);

      ceb = 1'b0;
      settle("settle1");

      for (int i = 0; i < 8; i++) begin
         check("run.p00", int'(a_div), p00[i % 4]);
         check("run.p01", int'(b_div), p01[i % 4]);
         tick();
      end
      for (int i = 0; i < 3; i++) tick();

      ceb = 1'b1;
      tick();
      chk_out("drain.j", 1, 1, 0, 0);
      tick();
      chk_out("drain.d1", 1, 1, 0, 1);
      tick();
      chk_out("drain.d2", 1, 0, 0, 1);
      tick();
      chk_out("drain.d3", 1, 0, 1, 1);
      tick();
      chk_out("drain.off", 0, 0, 0, 1);
      tick();
      chk_out("drain.stay", 0, 0, 0, 1);

      ceb = 1'b0;
      tick();
      tick();
      check("pulse.pre", int'(a_ready), 0);
      ceb = 1'b1;
      tick();
      ceb = 1'b0;
      tick();
      check("pulse.off", int'(a_ready), 0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 16) check("settle2.early", int'(a_ready), 0);
      end
      tick();
      check("settle2.ready", int'(a_ready), 1);
      chk_out("settle2.run", 1, 1, 0, 1);

      ceb = 1'b1;
      tick();
      ceb = 1'b0;
      tick();
      chk_out("reen.drain", 1, 0, 0, 2);
      tick();
      chk_out("reen.d3", 1, 0, 1, 2);
      tick();
      chk_out("reen.d0", 1, 1, 0, 2);
      tick();
      chk_out("reen.d1", 1, 1, 0, 2);

      rst = 1'b1;
      tick();
      chk_out("rst.run", 0, 0, 0, 0);
      rst = 1'b0;

      ceb = 1'b0;
      settle("settle3");
      for (int i = 0; i < 600; i++) begin
         ceb = (i % 2 == 0);
         tick();
         if (i == 199) check("sat.100", int'(a_dis), 100);
         if (i == 507) check("sat.254", int'(a_dis), 254);
         if (i == 509) check("sat.255", int'(a_dis), 255);
         if (i == 511) check("sat.hold", int'(a_dis), 255);
      end
      check("sat.final", int'(a_dis), 255);
      check("sat.final_b", int'(b_dis), 255);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
